// File: rtl/button_input_port_if.sv
// Read-port bundle between the CPU load path and the button input port.
// The CPU side drives the strobe and word index; the port returns registered data.
interface button_input_port_if;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/button_input_port.sv
// Board button/switch input port: synchronizes and debounces raw pins, flags presses,
// counts presses per button and exposes a 4-word read-only register window.
module button_input_port #(
  parameter int N_BTNS          = 2,
  parameter int N_SW            = 1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_BTNS-1:0]      btns_raw_i,
  input  logic [N_SW-1:0]        sw_raw_i,
  button_input_port_if.slave     bus,
  output logic [N_BTNS-1:0]      btn_level_o,
  output logic [N_BTNS-1:0]      btn_press_o,
  output logic                   irq_o
);

  localparam int N_IN = N_BTNS + N_SW;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]   ID_WORD = 32'hB770_0000 | (32'(N_SW) << 8) | 32'(N_BTNS);

  logic [N_IN-1:0]   raw_s;
  logic [N_IN-1:0]   sync1_q, sync2_q;
  logic [N_IN-1:0]   stable_q, stable_d;
  logic [CW-1:0]     cnt_q [N_IN];
  logic [CW-1:0]     cnt_d [N_IN];
  logic [N_BTNS-1:0] btn_s, btn_prev_q, press_q, press_d;
  logic [N_SW-1:0]   sw_s;
  logic [N_BTNS-1:0] ev_q, ev_d, ev_clr_s;
  logic [7:0]        pc_q [N_BTNS];
  logic [7:0]        pc_d [N_BTNS];
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       status_s, events_s, counts_s;

  assign raw_s = {sw_raw_i, btns_raw_i};
  assign btn_s = stable_q[N_BTNS-1:0];
  assign sw_s  = stable_q[N_IN-1:N_BTNS];

  // Debounce: the stable value flips on the DEBOUNCE_CYCLES-th consecutive differing synced sample.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = {CW{1'b0}};
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = {CW{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  always_comb begin
    status_s = 32'h0;
    events_s = 32'h0;
    counts_s = 32'h0;
    status_s[N_BTNS-1:0]  = btn_s;
    status_s[16 +: N_SW]  = sw_s;
    events_s[N_BTNS-1:0]  = ev_q;
    for (int i = 0; i < N_BTNS; i++) begin
      counts_s[8*i +: 8] = pc_q[i];
    end
  end

  // Read mux and press bookkeeping; a read sees ev before its own clear, and a new press wins over the clear.
  always_comb begin
    rdata_d  = rdata_q;
    ev_clr_s = {N_BTNS{1'b0}};
    if (bus.rd_en) begin
      case (bus.addr)
        2'd0:    rdata_d = status_s;
        2'd1: begin
          rdata_d  = events_s;
          ev_clr_s = ev_q;
        end
        2'd2:    rdata_d = counts_s;
        2'd3:    rdata_d = ID_WORD;
        default: rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
    press_d = btn_s & ~btn_prev_q;
    ev_d    = (ev_q & ~ev_clr_s) | press_q;
    irq_d   = |ev_d;
    for (int i = 0; i < N_BTNS; i++) begin
      pc_d[i] = pc_q[i] + {7'd0, press_q[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= {N_IN{1'b0}};
      sync2_q    <= {N_IN{1'b0}};
      stable_q   <= {N_IN{1'b0}};
      btn_prev_q <= {N_BTNS{1'b0}};
      press_q    <= {N_BTNS{1'b0}};
      ev_q       <= {N_BTNS{1'b0}};
      irq_q      <= 1'b0;
      rdata_q    <= 32'h0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
      for (int i = 0; i < N_BTNS; i++) begin
        pc_q[i] <= 8'h00;
      end
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      btn_prev_q <= btn_s;
      press_q    <= press_d;
      ev_q       <= ev_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      for (int i = 0; i < N_BTNS; i++) begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign bus.rdata   = rdata_q;
  assign btn_level_o = btn_s;
  assign btn_press_o = press_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_button_input_port.sv
// Self-checking bench for button_input_port (DEBOUNCE_CYCLES=4, N_BTNS=2, N_SW=1):
// directed scenarios plus random pin activity, every cycle compared with a window-based model.
module tb_button_input_port;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btns_raw = 2'b00;
  logic       sw_raw = 1'b0;
  logic [1:0] btn_level, btn_press;
  logic       irq;
  int         tests = 0;
  int         fails = 0;

  button_input_port_if bus();

  button_input_port #(.N_BTNS(2), .N_SW(1), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btns_raw_i(btns_raw), .sw_raw_i(sw_raw),
    .bus(bus), .btn_level_o(btn_level), .btn_press_o(btn_press), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a flip happens when the last D synced samples all disagree with the level.
  logic [2:0]  m_q[$];
  logic [2:0]  m_hist[$];
  logic [2:0]  m_lvl;
  logic [1:0]  m_lvl_d1, m_press, m_ev;
  logic [7:0]  m_pc[2];
  logic        m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_q = {3'b000, 3'b000};
    m_hist = {};
    m_lvl = 3'b000; m_lvl_d1 = 2'b00; m_press = 2'b00; m_ev = 2'b00;
    m_pc[0] = 8'h00; m_pc[1] = 8'h00; m_irq = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] syn, nl, ol;
    logic [1:0] old_ev, old_press, clr;
    logic       diff;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      ol = m_lvl; old_ev = m_ev; old_press = m_press;
      m_q.push_back({sw_raw, btns_raw});
      syn = m_q.pop_front();
      m_hist.push_back(syn);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      nl = ol;
      for (int i = 0; i < 3; i++) begin
        diff = (m_hist.size() == D);
        foreach (m_hist[j]) if (m_hist[j][i] == ol[i]) diff = 1'b0;
        if (diff) nl[i] = ~ol[i];
      end
      clr = 2'b00;
      if (bus.rd_en) begin
        case (bus.addr)
          2'd0: m_rdata = {15'd0, ol[2], 14'd0, ol[1:0]};
          2'd1: begin m_rdata = {30'd0, old_ev}; clr = old_ev; end
          2'd2: m_rdata = {16'd0, m_pc[1], m_pc[0]};
          default: m_rdata = 32'hB770_0102;
        endcase
      end
      m_ev = (old_ev & ~clr) | old_press;
      m_irq = |m_ev;
      for (int i = 0; i < 2; i++) m_pc[i] = m_pc[i] + {7'd0, old_press[i]};
      m_press = ol[1:0] & ~m_lvl_d1;
      m_lvl_d1 = ol[1:0];
      m_lvl = nl;
    end
    #1;
    chk("btn_level", {30'd0, btn_level}, {30'd0, m_lvl[1:0]});
    chk("btn_press", {30'd0, btn_press}, {30'd0, m_press});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("rdata", bus.rdata, m_rdata);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] data);
    bus.rd_en = 1'b1; bus.addr = a;
    tick();
    bus.rd_en = 1'b0;
    data = bus.rdata;
  endtask

  task automatic press(input int b);
    btns_raw[b] = 1'b1; ticks(D + 2);
    btns_raw[b] = 1'b0; ticks(D + 2);
  endtask

  logic [31:0] d;

  initial begin
    bus.rd_en = 1'b0; bus.addr = 2'd0;
    model_reset();

    // 1: reset with pins held high, then release and time the debounce
    btns_raw = 2'b11;
    ticks(3);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_level", {30'd0, btn_level}, 32'h0);
    #2 reset = 1'b1;
    ticks(5);
    chk("lvl_before_6", {30'd0, btn_level}, 32'h0);
    tick();
    chk("lvl_at_6", {30'd0, btn_level}, 32'h3);
    tick();
    chk("press_pulse", {30'd0, btn_press}, 32'h3);
    tick();
    chk("press_single", {30'd0, btn_press}, 32'h0);
    btns_raw = 2'b00;
    ticks(D + 4);
    rd(2'd1, d);
    chk("ev_after_t1", d, 32'h3);
    rd(2'd2, d);
    chk("counts_t1", d, 32'h0101);

    // 2: glitchy btn0 never reaches the threshold
    btns_raw[0] = 1'b1; ticks(3);
    btns_raw[0] = 1'b0; ticks(1);
    btns_raw[0] = 1'b1; ticks(3);
    btns_raw[0] = 1'b0; ticks(D + 4);
    chk("glitch_level", {30'd0, btn_level}, 32'h0);
    rd(2'd2, d);
    chk("glitch_counts", d, 32'h0101);

    // 3: single press of btn1 and read-to-clear
    press(1);
    chk("irq_set", {31'd0, irq}, 32'h1);
    rd(2'd1, d);
    chk("ev_btn1", d, 32'h2);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd(2'd1, d);
    chk("ev_reread", d, 32'h0);

    // 4: clearing read coincides with a press pulse
    btns_raw[0] = 1'b1;
    ticks(D + 3);
    chk("t4_pulse", {30'd0, btn_press}, 32'h1);
    rd(2'd1, d);
    chk("t4_rdata_bit0", {31'd0, d[0]}, 32'h0);
    chk("t4_irq", {31'd0, irq}, 32'h1);
    rd(2'd1, d);
    chk("t4_ev_kept", d, 32'h1);
    btns_raw[0] = 1'b0;
    ticks(D + 4);

    // random pin activity and reads
    for (int it = 0; it < 60; it++) begin
      btns_raw = 2'($urandom_range(0, 3));
      sw_raw = 1'($urandom_range(0, 1));
      for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
        bus.rd_en = 1'($urandom_range(0, 1));
        bus.addr = 2'($urandom_range(0, 3));
        tick();
      end
    end
    bus.rd_en = 1'b0; btns_raw = 2'b00; sw_raw = 1'b0;
    ticks(D + 4);

    // 5: counter wrap and switch status, from a fresh reset
    #2 reset = 1'b0;
    ticks(2);
    #2 reset = 1'b1;
    for (int p = 0; p < 257; p++) press(0);
    rd(2'd2, d);
    chk("counts_wrap", d, 32'h1);
    sw_raw = 1'b1;
    ticks(6);
    rd(2'd0, d);
    chk("status_sw", d, 32'h0001_0000);

    // 6: ID word, then async reset in the middle of a debounce
    rd(2'd3, d);
    chk("id_word", d, 32'hB770_0102);
    btns_raw = 2'b10;
    ticks(3);
    #2 reset = 1'b0;
    #1;
    chk("async_rdata", bus.rdata, 32'h0);
    chk("async_level", {30'd0, btn_level}, 32'h0);
    chk("async_press", {30'd0, btn_press}, 32'h0);
    chk("async_irq", {31'd0, irq}, 32'h0);
    model_reset();
    ticks(2);
    #2 reset = 1'b1;
    btns_raw = 2'b00; sw_raw = 1'b0;
    ticks(D + 4);
    rd(2'd2, d);
    chk("counts_after_reset", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
